// File: rtl/clk_set_pkg.sv
// Shared constants for the clock/date-setting datapath.
// Provides the moduli for each time field, their widths, and a constant
// function for deriving a counter width from a modulus.
package clk_set_pkg;

    localparam int unsigned SEC_MOD = 60;
    localparam int unsigned MIN_MOD = 60;
    localparam int unsigned HR_MOD  = 24;
    localparam int unsigned DAY_MOD = 31;

    localparam int unsigned W_SEC = 6;
    localparam int unsigned W_HR  = 5;

    // Smallest r with 2**r >= n (n >= 1).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = unsigned'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// 1-bit synchronous rising-edge detector.
// Ports:
//   clk_i     - clock
//   reset_i   - synchronous active-high reset
//   d_i       - level input
//   rise_c_o  - combinational pulse, high in the cycle d_i goes 0 -> 1
module edge_rise (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic rise_c_o
);

    logic d_q;

    // History follows the input even in reset, so a level held through
    // reset release is not mistaken for a new edge.
    always_ff @(posedge clk_i) begin
        d_q <= d_i;
    end

    assign rise_c_o = d_i & ~d_q & ~reset_i;

endmodule

// File: rtl/count_mod_updown.sv
// Parametrised modulo-MOD up/down counter with load, optional saturation,
// optional edge-qualified requests and registered carry/borrow pulses for
// cascading (seconds -> minutes -> hours).
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   en             - enables up/down stepping (not load)
//   up, down       - increment / decrement requests
//   load, din      - synchronous load; din >= MOD clamps to MOD-1
//   q              - current count, 0..MOD-1
//   carry, borrow  - one-cycle registered wrap pulses
//   at_max, at_min - combinational q == MOD-1 / q == 0
module count_mod_updown
    import clk_set_pkg::*;
#(
    parameter int unsigned MOD      = SEC_MOD,
    parameter int unsigned W        = clog2(MOD),
    parameter bit          SATURATE = 1'b0,
    parameter bit          EDGE_IN  = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         up,
    input  logic         down,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic         carry,
    output logic         borrow,
    output logic         at_max,
    output logic         at_min
);

    localparam logic [W-1:0] MAX_Q = W'(MOD - 1);
    // One extra bit so MOD == 2**W is representable in the load clamp.
    localparam logic [W:0]   MOD_X = (W+1)'(MOD);

    logic         inc_req;
    logic         dec_req;
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         carry_q;
    logic         carry_d;
    logic         borrow_q;
    logic         borrow_d;

    // Request qualification: edge-detected or raw level.
    generate
        if (EDGE_IN) begin : g_edge
            edge_rise u_up_edge (
                .clk_i    (clk),
                .reset_i  (reset),
                .d_i      (up),
                .rise_c_o (inc_req)
            );
            edge_rise u_down_edge (
                .clk_i    (clk),
                .reset_i  (reset),
                .d_i      (down),
                .rise_c_o (dec_req)
            );
        end else begin : g_level
            assign inc_req = up;
            assign dec_req = down;
        end
    endgenerate

    // Next-state: load, then simultaneous up+down (hold), then up, then down.
    always_comb begin
        q_d      = q_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            q_d = ({1'b0, din} < MOD_X) ? din : MAX_Q;
        end else if (en && inc_req && !dec_req) begin
            if (q_q != MAX_Q) begin
                q_d = q_q + W'(1);
            end else if (!SATURATE) begin
                q_d     = '0;
                carry_d = 1'b1;
            end
        end else if (en && dec_req && !inc_req) begin
            if (q_q != '0) begin
                q_d = q_q - W'(1);
            end else if (!SATURATE) begin
                q_d      = MAX_Q;
                borrow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q      <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign q      = q_q;
    assign carry  = carry_q;
    assign borrow = borrow_q;
    assign at_max = (q_q == MAX_Q);
    assign at_min = (q_q == '0);

endmodule

// File: tb/tb_count_mod_updown.sv
// Bench for count_mod_updown: six instances in different configurations,
// an arithmetic reference model checked every cycle, and directed
// sequences with hand-computed expectations.
//   0: MOD 60, wrap, level     1: MOD 60, saturate, level
//   2: MOD 60, wrap, edge      3: MOD 24 (W 5), wrap, level
//   4: seconds stage           5: minutes stage (up <- seconds carry)
module tb_count_mod_updown;
    import clk_set_pkg::*;

    localparam int N = 6;

    logic clk;
    logic rst [N];
    logic en  [N];
    logic up  [N];
    logic dn  [N];
    logic ld  [N];
    logic [5:0] din [N];

    logic [5:0] q_o   [N];
    logic       cy_o  [N];
    logic       bw_o  [N];
    logic       amax  [N];
    logic       amin  [N];
    logic [4:0] q_hr;

    int n_chk  = 0;
    int n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    count_mod_updown #(.MOD(60), .W(6), .SATURATE(1'b0), .EDGE_IN(1'b0)) u_wrap (
        .clk(clk), .reset(rst[0]), .en(en[0]), .up(up[0]), .down(dn[0]),
        .load(ld[0]), .din(din[0]), .q(q_o[0]), .carry(cy_o[0]),
        .borrow(bw_o[0]), .at_max(amax[0]), .at_min(amin[0]));

    count_mod_updown #(.MOD(60), .W(6), .SATURATE(1'b1), .EDGE_IN(1'b0)) u_sat (
        .clk(clk), .reset(rst[1]), .en(en[1]), .up(up[1]), .down(dn[1]),
        .load(ld[1]), .din(din[1]), .q(q_o[1]), .carry(cy_o[1]),
        .borrow(bw_o[1]), .at_max(amax[1]), .at_min(amin[1]));

    count_mod_updown #(.MOD(60), .W(6), .SATURATE(1'b0), .EDGE_IN(1'b1)) u_edge (
        .clk(clk), .reset(rst[2]), .en(en[2]), .up(up[2]), .down(dn[2]),
        .load(ld[2]), .din(din[2]), .q(q_o[2]), .carry(cy_o[2]),
        .borrow(bw_o[2]), .at_max(amax[2]), .at_min(amin[2]));

    count_mod_updown #(.MOD(HR_MOD), .W(clog2(HR_MOD)), .SATURATE(1'b0), .EDGE_IN(1'b0)) u_hr (
        .clk(clk), .reset(rst[3]), .en(en[3]), .up(up[3]), .down(dn[3]),
        .load(ld[3]), .din(din[3][4:0]), .q(q_hr), .carry(cy_o[3]),
        .borrow(bw_o[3]), .at_max(amax[3]), .at_min(amin[3]));
    assign q_o[3] = {1'b0, q_hr};

    count_mod_updown #(.MOD(SEC_MOD), .W(W_SEC), .SATURATE(1'b0), .EDGE_IN(1'b0)) u_sec (
        .clk(clk), .reset(rst[4]), .en(en[4]), .up(up[4]), .down(dn[4]),
        .load(ld[4]), .din(din[4]), .q(q_o[4]), .carry(cy_o[4]),
        .borrow(bw_o[4]), .at_max(amax[4]), .at_min(amin[4]));

    count_mod_updown #(.MOD(MIN_MOD), .W(W_SEC), .SATURATE(1'b0), .EDGE_IN(1'b0)) u_min (
        .clk(clk), .reset(rst[5]), .en(en[5]), .up(cy_o[4]), .down(dn[5]),
        .load(ld[5]), .din(din[5]), .q(q_o[5]), .carry(cy_o[5]),
        .borrow(bw_o[5]), .at_max(amax[5]), .at_min(amin[5]));

    function automatic int mod_of(input int i);
        return (i == 3) ? 24 : 60;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int mq    [N];
    bit mc    [N];
    bit mb    [N];
    bit mpu   [N];
    bit mpd   [N];
    bit valid [N];

    always @(posedge clk) begin
        int nq [N];
        bit nc [N];
        bit nb [N];
        bit npu [N];
        bit npd [N];
        for (int i = 0; i < N; i++) begin
            int m;
            int t;
            bit u;
            bit d;
            bit inc;
            bit dec;
            bit sat;
            m   = mod_of(i);
            sat = (i == 1);
            u   = (i == 5) ? mc[4] : up[i];
            d   = dn[i];
            nq[i] = mq[i];
            nc[i] = 1'b0;
            nb[i] = 1'b0;
            if (rst[i]) begin
                nq[i] = 0;
            end else begin
                inc = (i == 2) ? (u && !mpu[i]) : u;
                dec = (i == 2) ? (d && !mpd[i]) : d;
                if (ld[i]) begin
                    nq[i] = (int'(din[i]) < m) ? int'(din[i]) : m - 1;
                end else if (en[i] && (inc != dec)) begin
                    t = inc ? mq[i] + 1 : mq[i] - 1;
                    if (t >= m || t < 0) begin
                        if (!sat) begin
                            nq[i] = (t < 0) ? m - 1 : 0;
                            nc[i] = (t >= m);
                            nb[i] = (t < 0);
                        end
                    end else begin
                        nq[i] = t;
                    end
                end
            end
            npu[i] = u;
            npd[i] = d;
        end
        for (int i = 0; i < N; i++) begin
            mq[i]  = nq[i];
            mc[i]  = nc[i];
            mb[i]  = nb[i];
            mpu[i] = npu[i];
            mpd[i] = npd[i];
            if (rst[i]) valid[i] = 1'b1;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (valid[i]) begin
                chk($sformatf("model_q[%0d]", i),      int'(q_o[i]),  mq[i]);
                chk($sformatf("model_carry[%0d]", i),  int'(cy_o[i]), int'(mc[i]));
                chk($sformatf("model_borrow[%0d]", i), int'(bw_o[i]), int'(mb[i]));
                chk($sformatf("model_at_max[%0d]", i), int'(amax[i]), int'(mq[i] == mod_of(i) - 1));
                chk($sformatf("model_at_min[%0d]", i), int'(amin[i]), int'(mq[i] == 0));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; en[i] = 1'b0; up[i] = 1'b0; dn[i] = 1'b0;
            ld[i] = 1'b0; din[i] = '0; valid[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) rst[i] = 1'b0;
        chk("reset_q", int'(q_o[0]), 0);
        chk("reset_at_min", int'(amin[0]), 1);
        chk("reset_at_max", int'(amax[0]), 0);
        chk("reset_carry", int'(cy_o[0]), 0);

        // Up wrap over 61 level steps.
        en[0] = 1'b1; up[0] = 1'b1;
        for (int k = 1; k <= 61; k++) begin
            @(negedge clk);
            if (k == 1)  chk("upwrap_q1", int'(q_o[0]), 1);
            if (k == 59) begin
                chk("upwrap_q59", int'(q_o[0]), 59);
                chk("upwrap_at_max", int'(amax[0]), 1);
                chk("upwrap_carry_pre", int'(cy_o[0]), 0);
            end
            if (k == 60) begin
                chk("upwrap_q0", int'(q_o[0]), 0);
                chk("upwrap_carry", int'(cy_o[0]), 1);
            end
            if (k == 61) begin
                chk("upwrap_q_after", int'(q_o[0]), 1);
                chk("upwrap_carry_after", int'(cy_o[0]), 0);
            end
        end
        up[0] = 1'b0;

        // Down wrap from reset.
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0; dn[0] = 1'b1;
        @(negedge clk);
        chk("downwrap_q59", int'(q_o[0]), 59);
        chk("downwrap_borrow", int'(bw_o[0]), 1);
        @(negedge clk);
        chk("downwrap_q58", int'(q_o[0]), 58);
        chk("downwrap_borrow_after", int'(bw_o[0]), 0);
        dn[0] = 1'b0; en[0] = 1'b0;

        // Saturation at both ends.
        ld[1] = 1'b1; din[1] = 6'd59;
        @(negedge clk);
        ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b1;
        chk("sat_load59", int'(q_o[1]), 59);
        repeat (3) @(negedge clk);
        chk("sat_top_q", int'(q_o[1]), 59);
        chk("sat_top_carry", int'(cy_o[1]), 0);
        up[1] = 1'b0; ld[1] = 1'b1; din[1] = 6'd0;
        @(negedge clk);
        ld[1] = 1'b0; dn[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("sat_bot_q", int'(q_o[1]), 0);
        chk("sat_bot_borrow", int'(bw_o[1]), 0);
        dn[1] = 1'b0; en[1] = 1'b0;

        // Edge mode: held up steps once, simultaneous edges hold, load wins.
        en[2] = 1'b1; up[2] = 1'b1;
        repeat (10) @(negedge clk);
        chk("edge_held_once", int'(q_o[2]), 1);
        up[2] = 1'b0;
        @(negedge clk);
        up[2] = 1'b1; dn[2] = 1'b1;
        @(negedge clk);
        chk("edge_both_hold", int'(q_o[2]), 1);
        up[2] = 1'b0; dn[2] = 1'b0;
        @(negedge clk);
        ld[2] = 1'b1; din[2] = 6'd7; up[2] = 1'b1;
        @(negedge clk);
        chk("edge_load_wins", int'(q_o[2]), 7);
        ld[2] = 1'b0; up[2] = 1'b0; dn[2] = 1'b1;
        @(negedge clk);
        chk("edge_down_step", int'(q_o[2]), 6);
        dn[2] = 1'b0;
        // Edge while disabled is lost.
        en[2] = 1'b0; up[2] = 1'b1;
        @(negedge clk);
        en[2] = 1'b1;
        repeat (2) @(negedge clk);
        chk("edge_lost_when_disabled", int'(q_o[2]), 6);
        // Up held through reset release does not step.
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        repeat (3) @(negedge clk);
        chk("edge_no_step_on_release", int'(q_o[2]), 0);
        up[2] = 1'b0;
        @(negedge clk);
        up[2] = 1'b1;
        @(negedge clk);
        chk("edge_step_after_rearm", int'(q_o[2]), 1);
        up[2] = 1'b0; en[2] = 1'b0;

        // Load clamp and reset priority on the hours counter.
        ld[3] = 1'b1; din[3] = 6'd30;
        @(negedge clk);
        chk("hr_clamp_q", int'(q_o[3]), 23);
        chk("hr_clamp_at_max", int'(amax[3]), 1);
        rst[3] = 1'b1; din[3] = 6'd5;
        @(negedge clk);
        chk("hr_reset_q", int'(q_o[3]), 0);
        chk("hr_reset_at_min", int'(amin[3]), 1);
        chk("hr_reset_carry", int'(cy_o[3]), 0);
        chk("hr_reset_borrow", int'(bw_o[3]), 0);
        rst[3] = 1'b0; din[3] = 6'd23;
        @(negedge clk);
        ld[3] = 1'b0; en[3] = 1'b1; up[3] = 1'b1;
        @(negedge clk);
        chk("hr_wrap_q", int'(q_o[3]), 0);
        chk("hr_wrap_carry", int'(cy_o[3]), 1);
        up[3] = 1'b0; en[3] = 1'b0;

        // Cascade seconds -> minutes.
        en[5] = 1'b1;
        ld[4] = 1'b1; din[4] = 6'd59;
        ld[5] = 1'b1; din[5] = 6'd59;
        @(negedge clk);
        ld[4] = 1'b0; ld[5] = 1'b0;
        chk("casc_sec_pre", int'(q_o[4]), 59);
        chk("casc_min_pre", int'(q_o[5]), 59);
        en[4] = 1'b1; up[4] = 1'b1;
        @(negedge clk);
        up[4] = 1'b0;
        chk("casc_sec_wrap", int'(q_o[4]), 0);
        chk("casc_sec_carry", int'(cy_o[4]), 1);
        chk("casc_min_hold", int'(q_o[5]), 59);
        @(negedge clk);
        chk("casc_min_wrap", int'(q_o[5]), 0);
        chk("casc_min_carry", int'(cy_o[5]), 1);
        @(negedge clk);
        chk("casc_min_carry_once", int'(cy_o[5]), 0);
        chk("casc_min_stays", int'(q_o[5]), 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
